speccfa_blocktable: RTL and testbench

- Parametrised successor to the Spec-CFA metadata peripheral.
- Holds the TOTAL/BLOCK_MIN/BLOCK_MAX metadata registers and a NUM_BLOCKS-entry speculation block table, both memory-mapped on the openMSP430 peripheral bus.
- Adds CTRL/STATUS registers with a write-lock, a sticky error flag, and a sequential lookup engine that searches the table for a (src,dest) pair on behalf of the CFA monitor.

---
 rtl/speccfa_pkg.sv | 35 +++
 rtl/speccfa_lookup_fsm.sv | 98 +++++++++
 rtl/speccfa_blocktable.sv | 155 +++++++++++++++
 tb/tb_speccfa_blocktable.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/speccfa_pkg.sv
// Shared constants, lookup FSM state encoding and byte-lane merge helper for the
// Spec-CFA block table peripheral.
package speccfa_pkg;

    localparam logic [2:0] TOTAL_OFF  = 3'd0;
    localparam logic [2:0] MIN_OFF    = 3'd1;
    localparam logic [2:0] MAX_OFF    = 3'd2;
    localparam logic [2:0] CTRL_OFF   = 3'd3;
    localparam logic [2:0] STATUS_OFF = 3'd4;

    localparam int TABLE_OFF    = 8;
    localparam int ENTRY_STRIDE = 4;

    localparam int CTRL_LOCK_BIT = 0;
    localparam int ST_BUSY_BIT   = 0;
    localparam int ST_LOCK_BIT   = 1;
    localparam int ST_ERR_BIT    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } lookup_state_t;

    function automatic logic [15:0] merge_bytes(input logic [15:0] cur,
                                                input logic [15:0] din,
                                                input logic [1:0]  we);
        logic [15:0] res;
        res = cur;
        if (we[0]) res[7:0]  = din[7:0];
        if (we[1]) res[15:8] = din[15:8];
        return res;
    endfunction

endpackage

// File: rtl/speccfa_lookup_fsm.sv
// Sequential (src,dest) search over the block table, one entry per cycle; done pulses
// k+2 cycles after the request for a hit at k. Requests while busy are dropped, no queueing.
module speccfa_lookup_fsm
    import speccfa_pkg::*;
#(
    parameter int IDX_W = 4
)(
    input  logic             mclk,
    input  logic             puc_rst_n,
    input  logic             lookup_req,
    input  logic [15:0]      lookup_src,
    input  logic [15:0]      lookup_dest,
    input  logic [IDX_W:0]   n_eff,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [15:0]      tbl_src,
    input  logic [15:0]      tbl_dest,
    input  logic [15:0]      tbl_word2,
    output logic             busy,
    output logic             lookup_done,
    output logic             lookup_hit,
    output logic [IDX_W-1:0] lookup_idx,
    output logic [7:0]       lookup_id,
    output logic [7:0]       lookup_len
);

    lookup_state_t    state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [15:0]      src_q, dest_q;
    logic             load_res, res_hit, latch_key, match, last;

    assign tbl_idx     = ptr_q;
    assign busy        = (state_q != IDLE);
    assign lookup_done = (state_q == DONE);
    assign match       = (tbl_src == src_q) && (tbl_dest == dest_q);
    assign last        = ({1'b0, ptr_q} == (n_eff - (IDX_W+1)'(1)));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        load_res  = 1'b0;
        res_hit   = 1'b0;
        latch_key = 1'b0;
        case (state_q)
            IDLE: begin
                if (lookup_req) begin
                    state_d   = SCAN;
                    ptr_d     = '0;
                    latch_key = 1'b1;
                end
            end
            SCAN: begin
                // An empty table still spends one SCAN cycle before reporting the miss.
                if (n_eff == '0) begin
                    state_d  = DONE;
                    load_res = 1'b1;
                end else if (match) begin
                    state_d  = DONE;
                    load_res = 1'b1;
                    res_hit  = 1'b1;
                end else if (last) begin
                    state_d  = DONE;
                    load_res = 1'b1;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            src_q      <= '0;
            dest_q     <= '0;
            lookup_hit <= 1'b0;
            lookup_idx <= '0;
            lookup_id  <= '0;
            lookup_len <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (latch_key) begin
                src_q  <= lookup_src;
                dest_q <= lookup_dest;
            end
            if (load_res) begin
                lookup_hit <= res_hit;
                lookup_idx <= res_hit ? ptr_q : '0;
                lookup_id  <= res_hit ? tbl_word2[15:8] : 8'h00;
                lookup_len <= res_hit ? tbl_word2[7:0]  : 8'h00;
            end
        end
    end

endmodule

// File: rtl/speccfa_blocktable.sv
// Spec-CFA metadata registers and speculation block table on the openMSP430 peripheral bus.
// Reads are combinational, writes land on the mclk edge; blocked writes are dropped and flag ERR.
module speccfa_blocktable
    import speccfa_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR  = 15'h0400,
    parameter int          NUM_BLOCKS = 16,
    parameter int          IDX_W      = 4
)(
    input  logic             mclk,
    input  logic             puc_rst_n,
    input  logic [13:0]      per_addr,
    input  logic [15:0]      per_din,
    input  logic             per_en,
    input  logic [1:0]       per_we,
    output logic [15:0]      per_dout,
    input  logic             lookup_req,
    input  logic [15:0]      lookup_src,
    input  logic [15:0]      lookup_dest,
    output logic             lookup_done,
    output logic             lookup_hit,
    output logic [IDX_W-1:0] lookup_idx,
    output logic [7:0]       lookup_id,
    output logic [7:0]       lookup_len,
    output logic [15:0]      total_blocks,
    output logic [15:0]      SPECCFA_BLOCKS_min,
    output logic [15:0]      SPECCFA_BLOCKS_max,
    output logic             locked
);

    localparam logic [13:0] BASE_WORD = BASE_ADDR[14:1];
    localparam logic [13:0] WIN_LIMIT = 14'(TABLE_OFF + ENTRY_STRIDE * NUM_BLOCKS);

    logic [15:0] tbl_src   [NUM_BLOCKS];
    logic [15:0] tbl_dest  [NUM_BLOCKS];
    logic [15:0] tbl_word2 [NUM_BLOCKS];
    logic        err_q, busy;

    // Unsigned wrap keeps addresses below the base outside the window.
    logic [13:0]      off;
    logic             in_win, reg_sel, tbl_sel;
    logic [IDX_W-1:0] ent;
    logic [1:0]       word;

    assign off     = per_addr - BASE_WORD;
    assign in_win  = (off < WIN_LIMIT);
    assign reg_sel = in_win && (off < 14'(TABLE_OFF));
    assign tbl_sel = in_win && !reg_sel;
    assign ent     = off[IDX_W+1:2] - IDX_W'(TABLE_OFF / ENTRY_STRIDE);
    assign word    = off[1:0];

    logic wr, wr_total, wr_min, wr_max, wr_ctrl, wr_status, wr_tbl, wr_drop;

    assign wr        = per_en && (per_we != 2'b00);
    assign wr_total  = wr && reg_sel && (off[2:0] == TOTAL_OFF);
    assign wr_min    = wr && reg_sel && (off[2:0] == MIN_OFF);
    assign wr_max    = wr && reg_sel && (off[2:0] == MAX_OFF);
    assign wr_ctrl   = wr && reg_sel && (off[2:0] == CTRL_OFF);
    assign wr_status = wr && reg_sel && (off[2:0] == STATUS_OFF);
    assign wr_tbl    = wr && tbl_sel;
    assign wr_drop   = (locked && (wr_total || wr_min || wr_max || wr_tbl)) ||
                       (busy && (wr_total || wr_tbl));

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            total_blocks       <= '0;
            SPECCFA_BLOCKS_min <= '0;
            SPECCFA_BLOCKS_max <= '0;
            locked             <= 1'b0;
            err_q              <= 1'b0;
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tbl_src[i]   <= '0;
                tbl_dest[i]  <= '0;
                tbl_word2[i] <= '0;
            end
        end else begin
            if (wr_total && !wr_drop) total_blocks       <= merge_bytes(total_blocks, per_din, per_we);
            if (wr_min && !wr_drop)   SPECCFA_BLOCKS_min <= merge_bytes(SPECCFA_BLOCKS_min, per_din, per_we);
            if (wr_max && !wr_drop)   SPECCFA_BLOCKS_max <= merge_bytes(SPECCFA_BLOCKS_max, per_din, per_we);
            if (wr_ctrl && per_we[0] && per_din[CTRL_LOCK_BIT]) locked <= 1'b1;
            if (wr_drop)
                err_q <= 1'b1;
            else if (wr_status && per_we[0] && per_din[ST_ERR_BIT])
                err_q <= 1'b0;
            if (wr_tbl && !wr_drop) begin
                case (word)
                    2'd0:    tbl_src[ent]   <= merge_bytes(tbl_src[ent], per_din, per_we);
                    2'd1:    tbl_dest[ent]  <= merge_bytes(tbl_dest[ent], per_din, per_we);
                    2'd2:    tbl_word2[ent] <= merge_bytes(tbl_word2[ent], per_din, per_we);
                    default: ;
                endcase
            end
        end
    end

    logic [15:0] status_word, ctrl_word;

    always_comb begin
        status_word              = 16'h0000;
        status_word[ST_BUSY_BIT] = busy;
        status_word[ST_LOCK_BIT] = locked;
        status_word[ST_ERR_BIT]  = err_q;
        ctrl_word                = 16'h0000;
        ctrl_word[CTRL_LOCK_BIT] = locked;
    end

    always_comb begin
        per_dout = 16'h0000;
        if (per_en && (per_we == 2'b00)) begin
            if (reg_sel) begin
                case (off[2:0])
                    TOTAL_OFF:  per_dout = total_blocks;
                    MIN_OFF:    per_dout = SPECCFA_BLOCKS_min;
                    MAX_OFF:    per_dout = SPECCFA_BLOCKS_max;
                    CTRL_OFF:   per_dout = ctrl_word;
                    STATUS_OFF: per_dout = status_word;
                    default:    per_dout = 16'h0000;
                endcase
            end else if (tbl_sel) begin
                case (word)
                    2'd0:    per_dout = tbl_src[ent];
                    2'd1:    per_dout = tbl_dest[ent];
                    2'd2:    per_dout = tbl_word2[ent];
                    default: per_dout = 16'h0000;
                endcase
            end
        end
    end

    logic [IDX_W:0]   n_eff;
    logic [IDX_W-1:0] scan_idx;

    assign n_eff = (total_blocks >= 16'(NUM_BLOCKS)) ? (IDX_W+1)'(NUM_BLOCKS)
                                                     : total_blocks[IDX_W:0];

    speccfa_lookup_fsm #(.IDX_W(IDX_W)) u_lookup (
        .mclk        (mclk),
        .puc_rst_n   (puc_rst_n),
        .lookup_req  (lookup_req),
        .lookup_src  (lookup_src),
        .lookup_dest (lookup_dest),
        .n_eff       (n_eff),
        .tbl_idx     (scan_idx),
        .tbl_src     (tbl_src[scan_idx]),
        .tbl_dest    (tbl_dest[scan_idx]),
        .tbl_word2   (tbl_word2[scan_idx]),
        .busy        (busy),
        .lookup_done (lookup_done),
        .lookup_hit  (lookup_hit),
        .lookup_idx  (lookup_idx),
        .lookup_id   (lookup_id),
        .lookup_len  (lookup_len)
    );

endmodule

// File: tb/tb_speccfa_blocktable.sv
// Scoreboard bench for speccfa_blocktable: stimulus queues expected reads and lookup results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_speccfa_blocktable;

    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic [13:0] per_addr = '0;
    logic [15:0] per_din = '0;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = 2'b00;
    logic [15:0] per_dout;
    logic        lookup_req = 1'b0;
    logic [15:0] lookup_src = '0;
    logic [15:0] lookup_dest = '0;
    logic        lookup_done, lookup_hit, locked;
    logic [3:0]  lookup_idx;
    logic [7:0]  lookup_id, lookup_len;
    logic [15:0] total_blocks, blk_min, blk_max;

    speccfa_blocktable dut (
        .mclk               (mclk),
        .puc_rst_n          (puc_rst_n),
        .per_addr           (per_addr),
        .per_din            (per_din),
        .per_en             (per_en),
        .per_we             (per_we),
        .per_dout           (per_dout),
        .lookup_req         (lookup_req),
        .lookup_src         (lookup_src),
        .lookup_dest        (lookup_dest),
        .lookup_done        (lookup_done),
        .lookup_hit         (lookup_hit),
        .lookup_idx         (lookup_idx),
        .lookup_id          (lookup_id),
        .lookup_len         (lookup_len),
        .total_blocks       (total_blocks),
        .SPECCFA_BLOCKS_min (blk_min),
        .SPECCFA_BLOCKS_max (blk_max),
        .locked             (locked)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct {
        int         req_cyc;
        int         lat;
        logic       hit;
        logic [3:0] idx;
        logic [7:0] id;
        logic [7:0] len;
    } lk_exp_t;

    lk_exp_t     lk_q[$];
    string       rd_name_q[$];
    logic [15:0] rd_exp_q[$];

    // Monitor: bus reads and lookup completions are checked against the queued expectations.
    always @(negedge mclk) begin
        if (puc_rst_n && per_en && per_we == 2'b00 && rd_exp_q.size() != 0) begin
            string       nm;
            logic [15:0] ex;
            nm = rd_name_q.pop_front();
            ex = rd_exp_q.pop_front();
            checks++;
            if (per_dout !== ex) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, per_dout, ex);
            end
        end
        if (lookup_done === 1'b1) begin
            checks++;
            if (lk_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                lk_exp_t e;
                e = lk_q.pop_front();
                if ((cyc - e.req_cyc) != e.lat || lookup_hit !== e.hit || lookup_idx !== e.idx ||
                    lookup_id !== e.id || lookup_len !== e.len) begin
                    errors++;
                    $display("FAIL lookup: got lat=%0d hit=%b idx=%0d id=%h len=%h expected lat=%0d hit=%b idx=%0d id=%h len=%h",
                             cyc - e.req_cyc, lookup_hit, lookup_idx, lookup_id, lookup_len,
                             e.lat, e.hit, e.idx, e.id, e.len);
                end
            end
        end
    end

    function automatic logic [13:0] reg_addr(input int o);
        return 14'(32'h0200 + o);
    endfunction

    function automatic logic [13:0] ent_addr(input int i, input int w);
        return 14'(32'h0200 + 8 + 4 * i + w);
    endfunction

    task automatic bus_wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        @(posedge mclk); #1;
        per_en = 1'b1; per_addr = a; per_din = d; per_we = we;
        @(posedge mclk); #1;
        per_en = 1'b0; per_we = 2'b00;
    endtask

    task automatic bus_rd(input logic [13:0] a, input logic [15:0] ex, input string nm);
        @(posedge mclk); #1;
        rd_name_q.push_back(nm);
        rd_exp_q.push_back(ex);
        per_en = 1'b1; per_addr = a; per_we = 2'b00;
        @(posedge mclk); #1;
        per_en = 1'b0;
    endtask

    task automatic write_entry(input int i, input logic [15:0] s, input logic [15:0] d, input logic [15:0] w2);
        bus_wr(ent_addr(i, 0), s, 2'b11);
        bus_wr(ent_addr(i, 1), d, 2'b11);
        bus_wr(ent_addr(i, 2), w2, 2'b11);
    endtask

    task automatic lookup(input logic [15:0] s, input logic [15:0] d, input int lat,
                          input logic hit, input logic [3:0] idx, input logic [7:0] id, input logic [7:0] len);
        lk_exp_t e;
        @(posedge mclk); #1;
        e.req_cyc = cyc; e.lat = lat; e.hit = hit; e.idx = idx; e.id = id; e.len = len;
        lk_q.push_back(e);
        lookup_req = 1'b1; lookup_src = s; lookup_dest = d;
        @(posedge mclk); #1;
        lookup_req = 1'b0;
    endtask

    task automatic wait_lookups;
        for (int i = 0; i < 60 && lk_q.size() != 0; i++) @(posedge mclk);
        if (lk_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL lookup_timeout: got %0d pending expected 0", lk_q.size());
            lk_q.delete();
        end
        repeat (3) @(posedge mclk);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, ex);
        end
    endtask

    initial begin
        repeat (3) @(posedge mclk);
        #1 puc_rst_n = 1'b1;
        @(negedge mclk);
        chk("reset_done", {15'b0, lookup_done}, 16'h0000);
        chk("reset_locked", {15'b0, locked}, 16'h0000);
        for (int o = 0; o < 6; o++) bus_rd(reg_addr(o), 16'h0000, $sformatf("reset_rd_off%0d", o));

        // Hit at index 2 with TOTAL=3, then a miss over the same range.
        bus_wr(reg_addr(0), 16'd3, 2'b11);
        write_entry(2, 16'hC010, 16'hC200, 16'h0705);
        bus_rd(ent_addr(2, 2), 16'h0705, "entry2_word2");
        bus_rd(ent_addr(2, 3), 16'h0000, "entry2_reserved");
        lookup(16'hC010, 16'hC200, 4, 1'b1, 4'd2, 8'h07, 8'h05);
        wait_lookups();
        chk("hit_held", {15'b0, lookup_hit}, 16'h0001);
        lookup(16'hC010, 16'hC201, 4, 1'b0, 4'd0, 8'h00, 8'h00);
        wait_lookups();

        // Lowest matching index wins.
        write_entry(0, 16'hC010, 16'hC200, 16'h1122);
        lookup(16'hC010, 16'hC200, 2, 1'b1, 4'd0, 8'h11, 8'h22);
        wait_lookups();

        bus_wr(reg_addr(0), 16'd0, 2'b11);
        lookup(16'hC010, 16'hC200, 2, 1'b0, 4'd0, 8'h00, 8'h00);
        wait_lookups();

        write_entry(15, 16'hAAAA, 16'hBBBB, 16'h0F0E);
        bus_wr(reg_addr(0), 16'd2, 2'b11);
        lookup(16'hAAAA, 16'hBBBB, 3, 1'b0, 4'd0, 8'h00, 8'h00);
        wait_lookups();

        // TOTAL beyond table size clamps the scan to 16 entries.
        bus_wr(reg_addr(0), 16'd100, 2'b11);
        chk("total_port", total_blocks, 16'd100);
        lookup(16'hAAAA, 16'hBBBB, 17, 1'b1, 4'd15, 8'h0F, 8'h0E);
        wait_lookups();
        lookup(16'h0001, 16'h0002, 17, 1'b0, 4'd0, 8'h00, 8'h00);
        wait_lookups();

        bus_wr(reg_addr(1), 16'h1234, 2'b11);
        bus_wr(reg_addr(1), 16'hABCD, 2'b01);
        bus_rd(reg_addr(1), 16'h12CD, "min_low_lane");
        bus_wr(reg_addr(1), 16'h9900, 2'b10);
        bus_rd(reg_addr(1), 16'h99CD, "min_high_lane");
        chk("min_port", blk_min, 16'h99CD);
        bus_wr(reg_addr(5), 16'hFFFF, 2'b11);
        bus_rd(reg_addr(5), 16'h0000, "reserved_off5");
        bus_rd(reg_addr(4), 16'h0000, "status_clean");
        bus_wr(reg_addr(2), 16'h7777, 2'b11);

        // Table write and second request while busy: both dropped, ERR raised, one done.
        lookup(16'h0001, 16'h0002, 17, 1'b0, 4'd0, 8'h00, 8'h00);
        bus_wr(ent_addr(3, 0), 16'h5A5A, 2'b11);
        @(posedge mclk); #1;
        lookup_req = 1'b1; lookup_src = 16'hAAAA; lookup_dest = 16'hBBBB;
        @(posedge mclk); #1;
        lookup_req = 1'b0;
        bus_rd(reg_addr(4), 16'h0005, "status_busy_err");
        wait_lookups();
        repeat (20) @(posedge mclk);
        bus_rd(ent_addr(3, 0), 16'h0000, "busy_write_dropped");
        bus_rd(reg_addr(4), 16'h0004, "status_err_idle");
        bus_wr(reg_addr(4), 16'h0004, 2'b11);
        bus_rd(reg_addr(4), 16'h0000, "status_err_clear");

        bus_wr(reg_addr(3), 16'h0001, 2'b11);
        chk("locked_port", {15'b0, locked}, 16'h0001);
        bus_rd(reg_addr(3), 16'h0001, "ctrl_read");
        bus_wr(reg_addr(2), 16'h5555, 2'b11);
        bus_rd(reg_addr(2), 16'h7777, "max_locked");
        bus_rd(reg_addr(4), 16'h0006, "status_locked_err");
        bus_wr(reg_addr(4), 16'h0004, 2'b11);
        bus_rd(reg_addr(4), 16'h0002, "status_locked_clear");

        // Reset mid-scan: no done pulse, everything back to zero.
        @(posedge mclk); #1;
        lookup_req = 1'b1; lookup_src = 16'h0001; lookup_dest = 16'h0002;
        @(posedge mclk); #1;
        lookup_req = 1'b0;
        repeat (3) @(posedge mclk);
        #1 puc_rst_n = 1'b0;
        repeat (2) @(posedge mclk);
        #1 puc_rst_n = 1'b1;
        repeat (25) @(posedge mclk);
        for (int o = 0; o < 5; o++) bus_rd(reg_addr(o), 16'h0000, $sformatf("post_rst_off%0d", o));
        bus_rd(ent_addr(15, 0), 16'h0000, "post_rst_entry15");
        @(negedge mclk);
        chk("post_rst_locked", {15'b0, locked}, 16'h0000);
        chk("post_rst_hit", {15'b0, lookup_hit}, 16'h0000);

        repeat (3) @(posedge mclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
